// File: rtl/cci_mpf_csr_mmio_responder_if.sv
// MMIO CSR bus between the host shim and the CSR responder: one-cycle write
// strobe, read request strobe with transaction id, and a ready/valid read
// response channel.
interface cci_mpf_csr_mmio_responder_if;
    logic        mmio_wr_valid;
    logic [15:0] mmio_wr_addr;
    logic [63:0] mmio_wr_data;
    logic        mmio_rd_valid;
    logic [15:0] mmio_rd_addr;
    logic [8:0]  mmio_rd_tid;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic [8:0]  rsp_tid;

    // Host side: issues writes and read requests, consumes responses.
    modport master (
        output mmio_wr_valid, mmio_wr_addr, mmio_wr_data,
        output mmio_rd_valid, mmio_rd_addr, mmio_rd_tid,
        output rsp_ready,
        input  rsp_valid, rsp_data, rsp_tid
    );

    // Responder side.
    modport slave (
        input  mmio_wr_valid, mmio_wr_addr, mmio_wr_data,
        input  mmio_rd_valid, mmio_rd_addr, mmio_rd_tid,
        input  rsp_ready,
        output rsp_valid, rsp_data, rsp_tid
    );
endinterface

// File: rtl/cci_mpf_csr_mmio_responder.sv
// CSR block for the MPF VTP/WRO shims. Holds the VTP mode and page table
// base, counts VTP translation events, exposes WRO statistics, and answers
// host MMIO reads in order through a 4-deep request FIFO feeding a single
// registered response stage.
module cci_mpf_csr_mmio_responder (
    input  logic        clk,
    input  logic        reset_n,
    cci_mpf_csr_mmio_responder_if.slave mmio,

    output logic [1:0]  vtp_in_mode,
    output logic [41:0] vtp_in_page_table_base,
    output logic        vtp_in_page_table_base_valid,

    input  logic        vtp_out_event_4kb_hit_c0,
    input  logic        vtp_out_event_4kb_hit_c1,
    input  logic        vtp_out_event_4kb_miss,
    input  logic        vtp_out_event_2mb_hit_c0,
    input  logic        vtp_out_event_2mb_hit_c1,
    input  logic        vtp_out_event_2mb_miss,

    input  logic [63:0] wro_out_num_writes,
    input  logic [63:0] wro_out_num_reads,
    input  logic [63:0] wro_out_num_write_conflicts,
    input  logic [63:0] wro_out_num_read_conflicts,

    output logic        rd_overflow
);

    localparam logic [15:0] ADDR_MODE   = 16'h0000;
    localparam logic [15:0] ADDR_PT     = 16'h0008;
    localparam logic [15:0] ADDR_CLEAR  = 16'h0060;
    localparam int          NUM_EVT     = 6;
    localparam int          FIFO_DEPTH  = 4;

    // ------------------------------------------------------------------
    // CSR writes
    // ------------------------------------------------------------------
    logic        w_wr_mode;
    logic        w_wr_pt;
    logic        w_cnt_clear;
    logic        r_mode_en;
    logic        r_mode_inval;
    logic [41:0] r_pt_base;
    logic        r_pt_valid;
    logic        w_unused_wr_data;

    assign w_wr_mode   = mmio.mmio_wr_valid && (mmio.mmio_wr_addr == ADDR_MODE);
    assign w_wr_pt     = mmio.mmio_wr_valid && (mmio.mmio_wr_addr == ADDR_PT);
    assign w_cnt_clear = mmio.mmio_wr_valid && (mmio.mmio_wr_addr == ADDR_CLEAR);

    // Bits of the write word that no register stores.
    assign w_unused_wr_data = ^{mmio.mmio_wr_data[63:48], mmio.mmio_wr_data[5:2]};

    // Mode and page-table-base registers; the invalidate bit is a one-cycle pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode_en    <= 1'b0;
            r_mode_inval <= 1'b0;
            r_pt_base    <= '0;
            r_pt_valid   <= 1'b0;
        end else begin
            r_mode_inval <= w_wr_mode && mmio.mmio_wr_data[1];
            if (w_wr_mode) begin
                r_mode_en <= mmio.mmio_wr_data[0];
            end
            if (w_wr_pt) begin
                r_pt_base  <= mmio.mmio_wr_data[47:6];
                r_pt_valid <= 1'b1;
            end
        end
    end

    assign vtp_in_mode                  = {r_mode_inval, r_mode_en};
    assign vtp_in_page_table_base       = r_pt_base;
    assign vtp_in_page_table_base_valid = r_pt_valid;

    // ------------------------------------------------------------------
    // Event counters, indexed in register-map order starting at 0x10
    // ------------------------------------------------------------------
    logic [NUM_EVT-1:0] w_evt;
    logic [63:0]        w_evt_cnt [NUM_EVT];

    assign w_evt = {vtp_out_event_2mb_miss,
                    vtp_out_event_2mb_hit_c1,
                    vtp_out_event_2mb_hit_c0,
                    vtp_out_event_4kb_miss,
                    vtp_out_event_4kb_hit_c1,
                    vtp_out_event_4kb_hit_c0};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_EVT; gi++) begin : g_evt_cnt
            logic [63:0] r_cnt;

            // Clear wins over a coincident event; otherwise count and wrap naturally.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt <= '0;
                end else if (w_cnt_clear) begin
                    r_cnt <= '0;
                end else if (w_evt[gi]) begin
                    r_cnt <= r_cnt + 64'd1;
                end
            end

            assign w_evt_cnt[gi] = r_cnt;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read request FIFO
    // ------------------------------------------------------------------
    logic [15:0] r_fifo_addr [FIFO_DEPTH];
    logic [8:0]  r_fifo_tid  [FIFO_DEPTH];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;
    logic        w_fifo_empty;
    logic        w_fifo_full;
    logic        w_push;
    logic        w_pop;
    logic [15:0] w_head_addr;
    logic [8:0]  w_head_tid;

    logic        r_rsp_valid;
    logic [63:0] r_rsp_data;
    logic [8:0]  r_rsp_tid;
    logic        r_rd_overflow;

    assign w_fifo_empty = (r_count == 3'd0);
    assign w_fifo_full  = (r_count == 3'd4);
    // The head moves into the response stage whenever that stage is free or draining.
    assign w_pop        = !w_fifo_empty && (!r_rsp_valid || mmio.rsp_ready);
    // A full FIFO still accepts a request in a cycle where its head leaves.
    assign w_push       = mmio.mmio_rd_valid && (!w_fifo_full || w_pop);
    assign w_head_addr  = r_fifo_addr[r_rd_ptr];
    assign w_head_tid   = r_fifo_tid[r_rd_ptr];

    // Request storage; no reset needed since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= mmio.mmio_rd_addr;
            r_fifo_tid[r_wr_ptr]  <= mmio.mmio_rd_tid;
        end
    end

    // FIFO pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_rd_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            if (mmio.mmio_rd_valid && !w_push) begin
                r_rd_overflow <= 1'b1;
            end
        end
    end

    assign rd_overflow = r_rd_overflow;

    // ------------------------------------------------------------------
    // Read decode of the FIFO head and registered response stage
    // ------------------------------------------------------------------
    logic [63:0] w_rd_data;

    // Register values are sampled as they stand in the cycle the head is popped.
    always_comb begin
        w_rd_data = '0;
        case (w_head_addr)
            16'h0000: w_rd_data = {63'd0, r_mode_en};
            16'h0010: w_rd_data = w_evt_cnt[0];
            16'h0018: w_rd_data = w_evt_cnt[1];
            16'h0020: w_rd_data = w_evt_cnt[2];
            16'h0028: w_rd_data = w_evt_cnt[3];
            16'h0030: w_rd_data = w_evt_cnt[4];
            16'h0038: w_rd_data = w_evt_cnt[5];
            16'h0040: w_rd_data = wro_out_num_writes;
            16'h0048: w_rd_data = wro_out_num_reads;
            16'h0050: w_rd_data = wro_out_num_write_conflicts;
            16'h0058: w_rd_data = wro_out_num_read_conflicts;
            default:  w_rd_data = '0;
        endcase
    end

    // Response stage: load on pop, hold while stalled, empty once taken with nothing behind.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_tid   <= '0;
        end else if (w_pop) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rd_data;
            r_rsp_tid   <= w_head_tid;
        end else if (r_rsp_valid && mmio.rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign mmio.rsp_valid = r_rsp_valid;
    assign mmio.rsp_data  = r_rsp_data;
    assign mmio.rsp_tid   = r_rsp_tid;

endmodule

// File: tb/tb_cci_mpf_csr_mmio_responder.sv
// Directed bench for the MPF CSR MMIO responder: register map, event
// counters and clear, in-order read responses with backpressure and
// overflow, and asynchronous reset behaviour.
module tb_cci_mpf_csr_mmio_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  vtp_in_mode;
    logic [41:0] vtp_in_page_table_base;
    logic        vtp_in_page_table_base_valid;
    logic [5:0]  evt;
    logic [63:0] wro_w;
    logic [63:0] wro_r;
    logic [63:0] wro_wc;
    logic [63:0] wro_rc;
    logic        rd_overflow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cci_mpf_csr_mmio_responder_if mmio_if ();

    cci_mpf_csr_mmio_responder dut (
        .clk                          (clk),
        .reset_n                      (reset_n),
        .mmio                         (mmio_if),
        .vtp_in_mode                  (vtp_in_mode),
        .vtp_in_page_table_base       (vtp_in_page_table_base),
        .vtp_in_page_table_base_valid (vtp_in_page_table_base_valid),
        .vtp_out_event_4kb_hit_c0     (evt[0]),
        .vtp_out_event_4kb_hit_c1     (evt[1]),
        .vtp_out_event_4kb_miss       (evt[2]),
        .vtp_out_event_2mb_hit_c0     (evt[3]),
        .vtp_out_event_2mb_hit_c1     (evt[4]),
        .vtp_out_event_2mb_miss       (evt[5]),
        .wro_out_num_writes           (wro_w),
        .wro_out_num_reads            (wro_r),
        .wro_out_num_write_conflicts  (wro_wc),
        .wro_out_num_read_conflicts   (wro_rc),
        .rd_overflow                  (rd_overflow)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_csr(input logic [15:0] addr, input logic [63:0] data);
        mmio_if.mmio_wr_valid = 1'b1;
        mmio_if.mmio_wr_addr  = addr;
        mmio_if.mmio_wr_data  = data;
        tick();
        mmio_if.mmio_wr_valid = 1'b0;
    endtask

    // Single read with rsp_ready high and an empty pipeline: response is due
    // two cycles after the request cycle, then consumed on the following edge.
    task automatic rd_expect(input logic [15:0] addr, input logic [8:0] tid,
                             input logic [63:0] exp, input string tag);
        mmio_if.mmio_rd_valid = 1'b1;
        mmio_if.mmio_rd_addr  = addr;
        mmio_if.mmio_rd_tid   = tid;
        tick();
        mmio_if.mmio_rd_valid = 1'b0;
        check_val({tag, ".early"}, 64'(mmio_if.rsp_valid), 64'd0);
        tick();
        check_val({tag, ".valid"}, 64'(mmio_if.rsp_valid), 64'd1);
        check_val({tag, ".data"},  mmio_if.rsp_data, exp);
        check_val({tag, ".tid"},   64'(mmio_if.rsp_tid), 64'(tid));
        tick();
    endtask

    logic [15:0] ov_addr [6];
    logic [63:0] ov_exp  [6];

    initial begin
        reset_n               = 1'b0;
        evt                   = '0;
        wro_w                 = 64'h1111_2222_3333_4444;
        wro_r                 = 64'hFFFF_FFFF_FFFF_FFFF;
        wro_wc                = 64'h8000_0000_0000_0001;
        wro_rc                = 64'h0123_4567_89AB_CDEF;
        mmio_if.mmio_wr_valid = 1'b0;
        mmio_if.mmio_wr_addr  = '0;
        mmio_if.mmio_wr_data  = '0;
        mmio_if.mmio_rd_valid = 1'b0;
        mmio_if.mmio_rd_addr  = '0;
        mmio_if.mmio_rd_tid   = '0;
        mmio_if.rsp_ready     = 1'b1;

        // Reset state
        repeat (3) tick();
        check_val("rst.mode",     64'(vtp_in_mode), 64'd0);
        check_val("rst.base",     64'(vtp_in_page_table_base), 64'd0);
        check_val("rst.bvalid",   64'(vtp_in_page_table_base_valid), 64'd0);
        check_val("rst.rsp_v",    64'(mmio_if.rsp_valid), 64'd0);
        check_val("rst.rsp_d",    mmio_if.rsp_data, 64'd0);
        check_val("rst.rsp_tid",  64'(mmio_if.rsp_tid), 64'd0);
        check_val("rst.overflow", 64'(rd_overflow), 64'd0);
        reset_n = 1'b1;
        tick();
        rd_expect(16'h0010, 9'h001, 64'd0, "cnt0_after_rst");

        // Page table base: data[47:6] of 0x123456789AC0 is 0x48D159E26B
        wr_csr(16'h0008, 64'h0000_1234_5678_9AC0);
        check_val("pt.base",   64'(vtp_in_page_table_base), 64'h48_D159_E26B);
        check_val("pt.bvalid", 64'(vtp_in_page_table_base_valid), 64'd1);
        rd_expect(16'h0008, 9'h002, 64'd0, "pt_readback");
        check_val("pt.bvalid_hold", 64'(vtp_in_page_table_base_valid), 64'd1);

        // Mode write with invalidate pulse
        wr_csr(16'h0000, 64'h3);
        check_val("mode.pulse", 64'(vtp_in_mode), 64'h3);
        tick();
        check_val("mode.after", 64'(vtp_in_mode), 64'h1);
        rd_expect(16'h0000, 9'h003, 64'h1, "mode_rd");

        // Event counters
        evt[5] = 1'b1;
        repeat (5) tick();
        evt[5] = 1'b0;
        rd_expect(16'h0038, 9'h1A5, 64'd5, "2mb_miss");
        evt[1] = 1'b1;
        repeat (3) tick();
        evt[1] = 1'b0;
        rd_expect(16'h0018, 9'h004, 64'd3, "4kb_hit_c1");
        rd_expect(16'h0028, 9'h00A, 64'd0, "2mb_hit_c0");

        // Counter clear with coincident event
        evt[0] = 1'b1;
        repeat (7) tick();
        evt[0] = 1'b0;
        rd_expect(16'h0010, 9'h005, 64'd7, "4kb_hit_c0");
        evt[0] = 1'b1;
        wr_csr(16'h0060, 64'hDEAD_BEEF_0000_0000);
        evt[0] = 1'b0;
        rd_expect(16'h0010, 9'h006, 64'd0, "clr_4kb_hit_c0");
        rd_expect(16'h0038, 9'h007, 64'd0, "clr_2mb_miss");
        evt[2] = 1'b1;
        repeat (2) tick();
        evt[2] = 1'b0;
        rd_expect(16'h0020, 9'h00B, 64'd2, "4kb_miss_post_clr");

        // WRO statistics and unmapped/write-only addresses
        rd_expect(16'h0040, 9'h0C0, 64'h1111_2222_3333_4444, "wro_writes");
        rd_expect(16'h0048, 9'h0C1, 64'hFFFF_FFFF_FFFF_FFFF, "wro_reads");
        rd_expect(16'h0050, 9'h0C2, 64'h8000_0000_0000_0001, "wro_wconf");
        rd_expect(16'h0058, 9'h0C3, 64'h0123_4567_89AB_CDEF, "wro_rconf");
        rd_expect(16'h0068, 9'h0C4, 64'd0, "unmapped");
        rd_expect(16'h0060, 9'h0C5, 64'd0, "clear_rd");

        // Write in the cycle the entry enters the response stage is not seen
        mmio_if.mmio_rd_valid = 1'b1;
        mmio_if.mmio_rd_addr  = 16'h0000;
        mmio_if.mmio_rd_tid   = 9'h008;
        tick();
        mmio_if.mmio_rd_valid = 1'b0;
        wr_csr(16'h0000, 64'h0);
        check_val("sample.valid", 64'(mmio_if.rsp_valid), 64'd1);
        check_val("sample.data",  mmio_if.rsp_data, 64'd1);
        check_val("sample.mode",  64'(vtp_in_mode), 64'd0);
        tick();

        // Simultaneous read and write are both accepted
        mmio_if.mmio_rd_valid = 1'b1;
        mmio_if.mmio_rd_addr  = 16'h0000;
        mmio_if.mmio_rd_tid   = 9'h009;
        wr_csr(16'h0000, 64'h1);
        mmio_if.mmio_rd_valid = 1'b0;
        tick();
        check_val("simul.valid", 64'(mmio_if.rsp_valid), 64'd1);
        check_val("simul.data",  mmio_if.rsp_data, 64'd1);
        check_val("simul.tid",   64'(mmio_if.rsp_tid), 64'h009);
        check_val("simul.mode",  64'(vtp_in_mode), 64'd1);
        tick();

        // Backpressure: six reads, five retained, sixth dropped
        ov_addr[0] = 16'h0040; ov_exp[0] = 64'h1111_2222_3333_4444;
        ov_addr[1] = 16'h0048; ov_exp[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        ov_addr[2] = 16'h0050; ov_exp[2] = 64'h8000_0000_0000_0001;
        ov_addr[3] = 16'h0058; ov_exp[3] = 64'h0123_4567_89AB_CDEF;
        ov_addr[4] = 16'h0000; ov_exp[4] = 64'h1;
        ov_addr[5] = 16'h0068; ov_exp[5] = 64'h0;
        check_val("ovf.before", 64'(rd_overflow), 64'd0);
        mmio_if.rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mmio_if.mmio_rd_valid = 1'b1;
            mmio_if.mmio_rd_addr  = ov_addr[i];
            mmio_if.mmio_rd_tid   = 9'(9'h010 + i);
            tick();
        end
        mmio_if.mmio_rd_valid = 1'b0;
        check_val("ovf.flag", 64'(rd_overflow), 64'd1);
        for (int i = 0; i < 2; i++) begin
            check_val("ovf.stall_v",   64'(mmio_if.rsp_valid), 64'd1);
            check_val("ovf.stall_tid", 64'(mmio_if.rsp_tid), 64'h010);
            check_val("ovf.stall_d",   mmio_if.rsp_data, ov_exp[0]);
            tick();
        end
        mmio_if.rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("ovf.rsp%0d_v", i),   64'(mmio_if.rsp_valid), 64'd1);
            check_val($sformatf("ovf.rsp%0d_tid", i), 64'(mmio_if.rsp_tid), 64'(9'h010 + i));
            check_val($sformatf("ovf.rsp%0d_d", i),   mmio_if.rsp_data, ov_exp[i]);
            tick();
        end
        check_val("ovf.drained", 64'(mmio_if.rsp_valid), 64'd0);
        tick();
        check_val("ovf.no_extra", 64'(mmio_if.rsp_valid), 64'd0);
        check_val("ovf.sticky",   64'(rd_overflow), 64'd1);

        // Asynchronous reset with reads queued
        mmio_if.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mmio_if.mmio_rd_valid = 1'b1;
            mmio_if.mmio_rd_addr  = 16'h0040;
            mmio_if.mmio_rd_tid   = 9'(9'h020 + i);
            tick();
        end
        mmio_if.mmio_rd_valid = 1'b0;
        check_val("arst.pre_v", 64'(mmio_if.rsp_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("arst.rsp_v",    64'(mmio_if.rsp_valid), 64'd0);
        check_val("arst.rsp_d",    mmio_if.rsp_data, 64'd0);
        check_val("arst.rsp_tid",  64'(mmio_if.rsp_tid), 64'd0);
        check_val("arst.mode",     64'(vtp_in_mode), 64'd0);
        check_val("arst.base",     64'(vtp_in_page_table_base), 64'd0);
        check_val("arst.bvalid",   64'(vtp_in_page_table_base_valid), 64'd0);
        check_val("arst.overflow", 64'(rd_overflow), 64'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        mmio_if.rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val($sformatf("arst.quiet%0d", i), 64'(mmio_if.rsp_valid), 64'd0);
        end
        rd_expect(16'h0048, 9'h033, 64'hFFFF_FFFF_FFFF_FFFF, "post_rst_rd");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
